// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results directly and completes loads by
// waiting for the data-memory response, aligning and extending the returned
// word, and writing the result to the register file. Faulting loads raise a
// one-cycle load_err_o pulse instead of writing.
//
// Handshake: an instruction moves from MEM into this stage on any rising clock
// edge where mem_valid_i && mem_ready_o. mem_ready_o is high only while no load
// is outstanding, so it never depends on mem_valid_i. dmem_rvalid_i is a
// one-shot response: it is sampled only while a load is outstanding.
module wb_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic        mem_rd_wen_i,
    input  logic [4:0]  mem_rd_addr_i,
    input  logic        mem_is_load_i,
    input  logic [2:0]  mem_load_type_i,
    input  logic [1:0]  mem_addr_lo_i,
    input  logic [31:0] mem_alu_data_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic        wen_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        load_err_o,
    output logic [31:0] retired_cnt_o,
    output logic        dbg_state_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]  r_state;
    logic [4:0]  r_rd;
    logic        r_rd_wen;
    logic [2:0]  r_type;
    logic [1:0]  r_off;
    logic        r_wen;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_load_err;
    logic [31:0] r_retired_cnt;

    logic        w_accept;
    logic        w_legal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign mem_ready_o   = (r_state == S_IDLE);
    assign w_accept      = mem_valid_i && mem_ready_o;
    assign wen_o         = r_wen;
    assign wr_addr_o     = r_wr_addr;
    assign wr_data_o     = r_wr_data;
    assign load_err_o    = r_load_err;
    assign retired_cnt_o = r_retired_cnt;
    assign dbg_state_o   = r_state;

    // Decide whether the incoming load's type and byte offset are legal.
    always_comb begin
        w_legal = 1'b0;
        case (mem_load_type_i)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~mem_addr_lo_i[0];
            3'b010:         w_legal = (mem_addr_lo_i == 2'b00);
            default:        w_legal = 1'b0;
        endcase
    end

    // Pick the addressed byte/half from the response and extend per load type.
    always_comb begin
        w_byte = dmem_rdata_i[7:0];
        case (r_off)
            2'd0: w_byte = dmem_rdata_i[7:0];
            2'd1: w_byte = dmem_rdata_i[15:8];
            2'd2: w_byte = dmem_rdata_i[23:16];
            2'd3: w_byte = dmem_rdata_i[31:24];
            default: w_byte = dmem_rdata_i[7:0];
        endcase
        w_half = r_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (r_type)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem_rdata_i;
        endcase
    end

    // Stage state, write port and retire counter; write/fault are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_rd          <= 5'd0;
            r_rd_wen      <= 1'b0;
            r_type        <= 3'd0;
            r_off         <= 2'd0;
            r_wen         <= 1'b0;
            r_wr_addr     <= 5'd0;
            r_wr_data     <= 32'd0;
            r_load_err    <= 1'b0;
            r_retired_cnt <= 32'd0;
        end else begin
            r_wen      <= 1'b0;
            r_load_err <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (!mem_is_load_i) begin
                        r_retired_cnt <= r_retired_cnt + 32'd1;
                        if (mem_rd_wen_i && (mem_rd_addr_i != 5'd0)) begin
                            r_wen     <= 1'b1;
                            r_wr_addr <= mem_rd_addr_i;
                            r_wr_data <= mem_alu_data_i;
                        end
                    end else if (w_legal) begin
                        r_rd     <= mem_rd_addr_i;
                        r_rd_wen <= mem_rd_wen_i;
                        r_type   <= mem_load_type_i;
                        r_off    <= mem_addr_lo_i;
                        r_state  <= S_WAIT;
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
            end else begin
                if (dmem_rvalid_i) begin
                    r_state <= S_IDLE;
                    if (dmem_err_i) begin
                        r_load_err <= 1'b1;
                    end else begin
                        r_retired_cnt <= r_retired_cnt + 32'd1;
                        if (r_rd_wen && (r_rd != 5'd0)) begin
                            r_wen     <= 1'b1;
                            r_wr_addr <= r_rd;
                            r_wr_data <= w_load_data;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed scenarios plus randomized traffic, with
// every cycle compared against a transaction-level model of the stage.
module tb_wb_stage;

  logic        clk;
  logic        rstn;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_rd_wen_i;
  logic [4:0]  mem_rd_addr_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_load_type_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_alu_data_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic        wen_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        load_err_o;
  logic [31:0] retired_cnt_o;
  logic        dbg_state_o;

  wb_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .mem_valid_i     (mem_valid_i),
    .mem_ready_o     (mem_ready_o),
    .mem_rd_wen_i    (mem_rd_wen_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_is_load_i   (mem_is_load_i),
    .mem_load_type_i (mem_load_type_i),
    .mem_addr_lo_i   (mem_addr_lo_i),
    .mem_alu_data_i  (mem_alu_data_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .dmem_err_i      (dmem_err_i),
    .wen_o           (wen_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .load_err_o      (load_err_o),
    .retired_cnt_o   (retired_cnt_o),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // A load is either outstanding or not; the record of it is kept in p_q.
  typedef struct packed {
    logic       wen;
    logic [4:0] rd;
    logic [2:0] t;
    logic [1:0] off;
  } pend_t;
  pend_t p_q[$];

  logic        e_wen;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_err;
  logic [31:0] e_cnt;

  function automatic int load_bytes(input logic [2:0] t);
    return 1 << int'(t[1:0]);
  endfunction

  function automatic bit load_legal(input logic [2:0] t, input logic [1:0] off);
    if (!(t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (int'(off) % load_bytes(t)) == 0;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] w);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    n = load_bytes(t);
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * int'(off))) & mask;
    if (!t[2] && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_complete(input logic wen, input logic [4:0] rd, input logic [31:0] d);
    e_cnt = e_cnt + 32'd1;
    if (wen && rd != 5'd0) begin
      e_wen  = 1'b1;
      e_addr = rd;
      e_data = d;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    pend_t p;
    if (!rstn) begin
      p_q.delete();
      e_wen = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_err = 1'b0; e_cnt = 32'd0;
    end else begin
      e_wen = 1'b0;
      e_err = 1'b0;
      if (p_q.size() == 0) begin
        if (mem_valid_i) begin
          if (!mem_is_load_i) model_complete(mem_rd_wen_i, mem_rd_addr_i, mem_alu_data_i);
          else if (load_legal(mem_load_type_i, mem_addr_lo_i)) begin
            p.wen = mem_rd_wen_i; p.rd = mem_rd_addr_i;
            p.t = mem_load_type_i; p.off = mem_addr_lo_i;
            p_q.push_back(p);
          end else e_err = 1'b1;
        end
      end else if (dmem_rvalid_i) begin
        p = p_q.pop_front();
        if (dmem_err_i) e_err = 1'b1;
        else model_complete(p.wen, p.rd, load_value(p.t, p.off, dmem_rdata_i));
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ready", 32'(mem_ready_o), 32'(p_q.size() == 0));
    chk("state", 32'(dbg_state_o), 32'(p_q.size() != 0));
    chk("wen", 32'(wen_o), 32'(e_wen));
    chk("load_err", 32'(load_err_o), 32'(e_err));
    chk("wr_addr", 32'(wr_addr_o), 32'(e_addr));
    chk("wr_data", wr_data_o, e_data);
    chk("retired_cnt", retired_cnt_o, e_cnt);
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    mem_valid_i = 1'b0; mem_rd_wen_i = 1'b0; mem_rd_addr_i = 5'd0;
    mem_is_load_i = 1'b0; mem_load_type_i = 3'd0; mem_addr_lo_i = 2'd0;
    mem_alu_data_i = 32'd0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0; dmem_err_i = 1'b0;
  endtask

  task automatic send_alu(input logic wen, input logic [4:0] rd, input logic [31:0] d);
    mem_valid_i = 1'b1; mem_is_load_i = 1'b0;
    mem_rd_wen_i = wen; mem_rd_addr_i = rd; mem_alu_data_i = d;
    step();
    mem_valid_i = 1'b0;
  endtask

  task automatic send_load(input logic [2:0] t, input logic [1:0] off, input logic [4:0] rd);
    mem_valid_i = 1'b1; mem_is_load_i = 1'b1; mem_rd_wen_i = 1'b1;
    mem_rd_addr_i = rd; mem_load_type_i = t; mem_addr_lo_i = off;
    step();
    mem_valid_i = 1'b0; mem_is_load_i = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d, input logic err);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = d; dmem_err_i = err;
    step();
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  int low_cnt;
  logic [31:0] cnt_save;

  initial begin
    idle_inputs();
    rstn = 1'b0;
    e_wen = 1'b0; e_addr = 5'd0; e_data = 32'd0; e_err = 1'b0; e_cnt = 32'd0;
    step();
    step();
    chk("reset_cnt_lit", retired_cnt_o, 32'd0);
    chk("reset_ready_lit", 32'(mem_ready_o), 32'd1);
    rstn = 1'b1;
    step();

    // Non-load to rd 5.
    send_alu(1'b1, 5'd5, 32'h1234_5678);
    chk("alu_wen_lit", 32'(wen_o), 32'd1);
    chk("alu_addr_lit", 32'(wr_addr_o), 32'd5);
    chk("alu_data_lit", wr_data_o, 32'h1234_5678);
    chk("alu_cnt_lit", retired_cnt_o, 32'd1);
    step();
    chk("wen_pulse_lit", 32'(wen_o), 32'd0);

    // Alignment and extension.
    send_load(3'b000, 2'd2, 5'd7);
    respond(32'h0080_0000, 1'b0);
    chk("lb_lit", wr_data_o, 32'hFFFF_FF80);
    send_load(3'b100, 2'd2, 5'd7);
    respond(32'h0080_0000, 1'b0);
    chk("lbu_lit", wr_data_o, 32'h0000_0080);
    send_load(3'b101, 2'd2, 5'd7);
    respond(32'h8001_0000, 1'b0);
    chk("lhu_lit", wr_data_o, 32'h0000_8001);

    // Delayed response: ready stays low until the response completes.
    low_cnt = 0;
    send_load(3'b010, 2'd0, 5'd3);
    if (!mem_ready_o) low_cnt++;
    repeat (3) begin
      step();
      if (!mem_ready_o) low_cnt++;
    end
    respond(32'hCAFE_F00D, 1'b0);
    chk("wait_low_cycles", 32'(low_cnt), 32'd4);
    chk("lw_wen_lit", 32'(wen_o), 32'd1);
    chk("lw_addr_lit", 32'(wr_addr_o), 32'd3);
    chk("lw_ready_lit", 32'(mem_ready_o), 32'd1);

    // Misaligned LW and bus error: fault pulse, no write, no count.
    cnt_save = e_cnt;
    send_load(3'b010, 2'd1, 5'd9);
    chk("mis_err_lit", 32'(load_err_o), 32'd1);
    chk("mis_ready_lit", 32'(mem_ready_o), 32'd1);
    chk("mis_cnt", retired_cnt_o, cnt_save);
    step();
    send_load(3'b001, 2'd0, 5'd9);
    respond(32'h1111_2222, 1'b1);
    chk("buserr_err_lit", 32'(load_err_o), 32'd1);
    chk("buserr_wen_lit", 32'(wen_o), 32'd0);
    chk("buserr_cnt", retired_cnt_o, cnt_save);

    // rd = 0 retires without writing; stray rvalid in IDLE is ignored.
    send_alu(1'b1, 5'd0, 32'hDEAD_BEEF);
    chk("rd0_wen_lit", 32'(wen_o), 32'd0);
    chk("rd0_cnt", retired_cnt_o, cnt_save + 32'd1);
    respond(32'h5555_5555, 1'b0);
    chk("stray_rvalid_wen_lit", 32'(wen_o), 32'd0);

    // Reset during WAIT drops the load.
    send_load(3'b010, 2'd0, 5'd4);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    respond(32'h7777_7777, 1'b0);
    chk("rst_wait_wen_lit", 32'(wen_o), 32'd0);
    chk("rst_wait_cnt_lit", retired_cnt_o, 32'd0);
    chk("rst_wait_ready_lit", 32'(mem_ready_o), 32'd1);

    // Counter wrap with back-to-back non-loads.
    force dut.r_retired_cnt = 32'hFFFF_FFFE;
    e_cnt = 32'hFFFF_FFFE;
    step();
    release dut.r_retired_cnt;
    step();
    mem_valid_i = 1'b1; mem_is_load_i = 1'b0; mem_rd_wen_i = 1'b1; mem_rd_addr_i = 5'd10;
    mem_alu_data_i = 32'hA; step();
    mem_rd_addr_i = 5'd11; mem_alu_data_i = 32'hB; step();
    chk("wrap_zero_lit", retired_cnt_o, 32'd0);
    chk("b2b_wen_lit", 32'(wen_o), 32'd1);
    mem_rd_addr_i = 5'd12; mem_alu_data_i = 32'hC; step();
    chk("wrap_one_lit", retired_cnt_o, 32'd1);
    chk("b2b_data_lit", wr_data_o, 32'hC);
    idle_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rstn            = ($urandom_range(0, 199) != 0);
      mem_valid_i     = $urandom_range(0, 1);
      mem_is_load_i   = $urandom_range(0, 1);
      mem_rd_wen_i    = ($urandom_range(0, 3) != 0);
      mem_rd_addr_i   = 5'($urandom_range(0, 31));
      mem_load_type_i = 3'($urandom_range(0, 7));
      mem_addr_lo_i   = 2'($urandom_range(0, 3));
      mem_alu_data_i  = $urandom;
      dmem_rvalid_i   = ($urandom_range(0, 9) < 3);
      dmem_rdata_i    = $urandom;
      dmem_err_i      = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
